// File: rtl/cnt_pkg.sv
// Shared types and helpers for the counter sequence checker.
//   state_e   : checker FSM states (2-bit encoding)
//   CNT_W_DEF : default width of the monitored count
//   sat_inc   : saturating increment for counters up to 32 bits wide
package cnt_pkg;

  localparam int unsigned CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_e;

  // Increment val, sticking at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational CNT_W-to-2**CNT_W one-hot decoder with enable.
//   en       : when low the output is all zeros
//   sel      : binary index to decode
//   onehot_c : one-hot result (combinational)
module onehot_dec #(
  parameter int unsigned CNT_W = 3
) (
  input  logic                    en,
  input  logic [CNT_W-1:0]        sel,
  output logic [(1<<CNT_W)-1:0]   onehot_c
);

  always_comb begin
    onehot_c = '0;
    if (en) begin
      onehot_c[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// Checks that a sampled up-counter advances by exactly one (mod 2**CNT_W),
// counts legal wraps and sequence errors, and latches a sticky fault after
// ERR_LIMIT consecutive errors. Also registers a one-hot decode of the
// last accepted sample for downstream phase selection.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear back to ACQUIRE (wins over count_vld)
//   count_vld   : count_in is valid this cycle
//   count_in    : counter value under check
//   onehot_out  : registered decode of the last accepted sample
//   tc_pulse    : one-cycle pulse on a legal max->0 wrap
//   wrap_count  : saturating count of legal wraps
//   seq_err     : one-cycle pulse on an illegal transition
//   err_count   : saturating count of all sequence errors
//   locked      : high while in TRACK
//   fault       : high in FAULT, sticky until clr or reset
module count_seq_checker
  import cnt_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned WRAP_W    = 8,
  parameter int unsigned ERR_W     = 8,
  parameter int unsigned ERR_LIMIT = 3,
  parameter bit          HOLD_OK   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  count_vld,
  input  logic [CNT_W-1:0]      count_in,
  output logic [(1<<CNT_W)-1:0] onehot_out,
  output logic                  tc_pulse,
  output logic [WRAP_W-1:0]     wrap_count,
  output logic                  seq_err,
  output logic [ERR_W-1:0]      err_count,
  output logic                  locked,
  output logic                  fault
);

  localparam int unsigned OH_W     = 1 << CNT_W;
  localparam int unsigned CONSEC_W = 4;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      prev_q, prev_d;
  logic [CONSEC_W-1:0]   consec_q, consec_d;
  logic [OH_W-1:0]       onehot_d;
  logic                  tc_d, seq_err_d, locked_d, fault_d;
  logic [WRAP_W-1:0]     wrap_d;
  logic [ERR_W-1:0]      err_d;
  logic [CNT_W-1:0]      exp_c;
  logic [OH_W-1:0]       dec_c;
  logic                  hit_limit_c;

  onehot_dec #(.CNT_W(CNT_W)) u_dec (
    .en       (count_vld),
    .sel      (count_in),
    .onehot_c (dec_c)
  );

  // Expected next value wraps naturally at CNT_W bits.
  assign exp_c       = prev_q + CNT_W'(1);
  assign hit_limit_c = ((5'(consec_q) + 5'd1) == 5'(ERR_LIMIT));

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    consec_d  = consec_q;
    onehot_d  = onehot_out;
    wrap_d    = wrap_count;
    err_d     = err_count;
    tc_d      = 1'b0;
    seq_err_d = 1'b0;

    if (clr) begin
      state_d  = ACQUIRE;
      prev_d   = '0;
      consec_d = '0;
      onehot_d = '0;
      wrap_d   = '0;
      err_d    = '0;
    end else begin
      unique case (state_q)
        ACQUIRE: begin
          if (count_vld) begin
            prev_d   = count_in;
            onehot_d = dec_c;
            state_d  = TRACK;
          end
        end
        TRACK: begin
          if (count_vld) begin
            if (count_in == exp_c) begin
              prev_d   = count_in;
              onehot_d = dec_c;
              consec_d = '0;
              if ((prev_q == {CNT_W{1'b1}}) && (count_in == '0)) begin
                tc_d   = 1'b1;
                wrap_d = WRAP_W'(sat_inc(32'(wrap_count), WRAP_W));
              end
            end else if (HOLD_OK && (count_in == prev_q)) begin
              consec_d = '0;
            end else begin
              // Illegal step: flag it and resync to the observed value.
              seq_err_d = 1'b1;
              err_d     = ERR_W'(sat_inc(32'(err_count), ERR_W));
              consec_d  = consec_q + CONSEC_W'(1);
              prev_d    = count_in;
              onehot_d  = dec_c;
              if (hit_limit_c) begin
                state_d  = FAULT;
                onehot_d = '0;
              end
            end
          end
        end
        FAULT: begin
          onehot_d = '0;
        end
        default: begin
          state_d  = ACQUIRE;
          onehot_d = '0;
        end
      endcase
    end

    locked_d = (state_d == TRACK);
    fault_d  = (state_d == FAULT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACQUIRE;
      prev_q     <= '0;
      consec_q   <= '0;
      onehot_out <= '0;
      tc_pulse   <= 1'b0;
      seq_err    <= 1'b0;
      wrap_count <= '0;
      err_count  <= '0;
      locked     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      consec_q   <= consec_d;
      onehot_out <= onehot_d;
      tc_pulse   <= tc_d;
      seq_err    <= seq_err_d;
      wrap_count <= wrap_d;
      err_count  <= err_d;
      locked     <= locked_d;
      fault      <= fault_d;
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// Self-checking bench for count_seq_checker: a default instance driven by a
// vector table, plus instances with HOLD_OK=0 and WRAP_W=2 sharing the same
// stimulus for the stall and wrap-saturation sequences.
module tb_count_seq_checker;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       count_vld;
  logic [2:0] count_in;

  logic [7:0] oh, oh_nh, oh_w2;
  logic       tc, tc_nh, tc_w2;
  logic [7:0] wrap, wrap_nh;
  logic [1:0] wrap_w2;
  logic       se, se_nh, se_w2;
  logic [7:0] ec, ec_nh, ec_w2;
  logic       lk, lk_nh, lk_w2;
  logic       ft, ft_nh, ft_w2;

  int n_tests = 0;
  int n_fail  = 0;

  count_seq_checker dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .count_vld(count_vld), .count_in(count_in),
    .onehot_out(oh), .tc_pulse(tc), .wrap_count(wrap), .seq_err(se),
    .err_count(ec), .locked(lk), .fault(ft)
  );

  count_seq_checker #(.HOLD_OK(1'b0)) dut_nh (
    .clk(clk), .rst_n(rst_n), .clr(clr), .count_vld(count_vld), .count_in(count_in),
    .onehot_out(oh_nh), .tc_pulse(tc_nh), .wrap_count(wrap_nh), .seq_err(se_nh),
    .err_count(ec_nh), .locked(lk_nh), .fault(ft_nh)
  );

  count_seq_checker #(.WRAP_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .count_vld(count_vld), .count_in(count_in),
    .onehot_out(oh_w2), .tc_pulse(tc_w2), .wrap_count(wrap_w2), .seq_err(se_w2),
    .err_count(ec_w2), .locked(lk_w2), .fault(ft_w2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       vld;
    logic [2:0] cin;
    logic [7:0] oh;
    logic       tc;
    logic [7:0] wrap;
    logic       se;
    logic [7:0] ec;
    logic       lk;
    logic       ft;
    string      tag;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic c, input logic v, input logic [2:0] ci,
                     input logic [7:0] e_oh, input logic e_tc, input logic [7:0] e_wr,
                     input logic e_se, input logic [7:0] e_ec, input logic e_lk,
                     input logic e_ft, input string tag);
    vec_t r;
    r.clr = c;  r.vld = v;  r.cin = ci;
    r.oh = e_oh; r.tc = e_tc; r.wrap = e_wr; r.se = e_se; r.ec = e_ec;
    r.lk = e_lk; r.ft = e_ft; r.tag = tag;
    vq.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and sample outputs 1 time unit after the edge.
  task automatic step(input logic c, input logic v, input logic [2:0] ci);
    clr = c; count_vld = v; count_in = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".oh"},   32'(oh),   32'h0);
    chk({tag, ".tc"},   32'(tc),   32'h0);
    chk({tag, ".wrap"}, 32'(wrap), 32'h0);
    chk({tag, ".se"},   32'(se),   32'h0);
    chk({tag, ".ec"},   32'(ec),   32'h0);
    chk({tag, ".lk"},   32'(lk),   32'h0);
    chk({tag, ".ft"},   32'(ft),   32'h0);
    chk({tag, ".w2_tc"},   32'(tc_w2),   32'h0);
    chk({tag, ".w2_wrap"}, 32'(wrap_w2), 32'h0);
    chk({tag, ".nh_se"},   32'(se_nh),   32'h0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; count_vld = 1'b0; count_in = '0;

    // Full count with one wrap.
    add(0,1,0, 8'h01,0,0,0,0,1,0,"acq0");
    add(0,1,1, 8'h02,0,0,0,0,1,0,"inc1");
    add(0,1,2, 8'h04,0,0,0,0,1,0,"inc2");
    add(0,1,3, 8'h08,0,0,0,0,1,0,"inc3");
    add(0,1,4, 8'h10,0,0,0,0,1,0,"inc4");
    add(0,1,5, 8'h20,0,0,0,0,1,0,"inc5");
    add(0,1,6, 8'h40,0,0,0,0,1,0,"inc6");
    add(0,1,7, 8'h80,0,0,0,0,1,0,"inc7");
    add(0,1,0, 8'h01,1,1,0,0,1,0,"wrap0");
    add(0,1,1, 8'h02,0,1,0,0,1,0,"postwrap1");
    // Skip error, resync, consecutive-error reset.
    add(1,0,0, 8'h00,0,0,0,0,0,0,"clrB");
    add(0,1,3, 8'h08,0,0,0,0,1,0,"acq3");
    add(0,1,4, 8'h10,0,0,0,0,1,0,"ok4");
    add(0,1,6, 8'h40,0,0,1,1,1,0,"skip6");
    add(0,1,7, 8'h80,0,0,0,1,1,0,"resync7");
    add(0,1,1, 8'h02,0,0,1,2,1,0,"err1");
    add(0,1,5, 8'h20,0,0,1,3,1,0,"err5_nofault");
    add(0,1,6, 8'h40,0,0,0,3,1,0,"ok6");
    add(0,0,2, 8'h40,0,0,0,3,1,0,"idle_hold");
    // Three consecutive errors into FAULT; FAULT freezes counters.
    add(1,0,0, 8'h00,0,0,0,0,0,0,"clrD");
    add(0,1,6, 8'h40,0,0,0,0,1,0,"acq6");
    add(0,1,7, 8'h80,0,0,0,0,1,0,"ok7");
    add(0,1,0, 8'h01,1,1,0,0,1,0,"wrapD");
    add(0,1,5, 8'h20,0,1,1,1,1,0,"fe1");
    add(0,1,2, 8'h04,0,1,1,2,1,0,"fe2");
    add(0,1,7, 8'h00,0,1,1,3,0,1,"fe3_fault");
    add(0,1,0, 8'h00,0,1,0,3,0,1,"fault_ign0");
    add(0,1,3, 8'h00,0,1,0,3,0,1,"fault_ign3");
    // clr with a valid sample: sample discarded, then reacquire.
    add(1,1,4, 8'h00,0,0,0,0,0,0,"clr_vld");
    add(0,0,0, 8'h00,0,0,0,0,0,0,"acq_idle");
    add(0,1,5, 8'h20,0,0,0,0,1,0,"acq5");
    add(0,0,3, 8'h20,0,0,0,0,1,0,"track_idle");

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].clr, vq[i].vld, vq[i].cin);
      chk({vq[i].tag, ".oh"},   32'(oh),   32'(vq[i].oh));
      chk({vq[i].tag, ".tc"},   32'(tc),   32'(vq[i].tc));
      chk({vq[i].tag, ".wrap"}, 32'(wrap), 32'(vq[i].wrap));
      chk({vq[i].tag, ".se"},   32'(se),   32'(vq[i].se));
      chk({vq[i].tag, ".ec"},   32'(ec),   32'(vq[i].ec));
      chk({vq[i].tag, ".lk"},   32'(lk),   32'(vq[i].lk));
      chk({vq[i].tag, ".ft"},   32'(ft),   32'(vq[i].ft));
    end

    // Stall 2,2,3: legal with HOLD_OK=1, one error with HOLD_OK=0.
    step(1, 0, 0);
    step(0, 1, 2);
    chk("hold_acq.se",    32'(se),    32'h0);
    chk("hold_acq.nh_se", 32'(se_nh), 32'h0);
    step(0, 1, 2);
    chk("hold_rep.se",    32'(se),    32'h0);
    chk("hold_rep.oh",    32'(oh),    32'h04);
    chk("hold_rep.nh_se", 32'(se_nh), 32'h1);
    chk("hold_rep.nh_ec", 32'(ec_nh), 32'h1);
    chk("hold_rep.nh_lk", 32'(lk_nh), 32'h1);
    step(0, 1, 3);
    chk("hold_3.se",    32'(se),    32'h0);
    chk("hold_3.oh",    32'(oh),    32'h08);
    chk("hold_3.ec",    32'(ec),    32'h0);
    chk("hold_3.nh_se", 32'(se_nh), 32'h0);
    chk("hold_3.nh_ec", 32'(ec_nh), 32'h1);

    // Five full wraps: 2-bit wrap counter saturates, tc_pulse keeps firing.
    step(1, 0, 0);
    step(0, 1, 0);
    for (int lap = 1; lap <= 5; lap++) begin
      for (int v = 1; v <= 7; v++) begin
        step(0, 1, 3'(v));
        chk($sformatf("lap%0d_v%0d.w2_tc", lap, v), 32'(tc_w2), 32'h0);
      end
      step(0, 1, 0);
      chk($sformatf("lap%0d.w2_tc", lap),   32'(tc_w2),   32'h1);
      chk($sformatf("lap%0d.w2_wrap", lap), 32'(wrap_w2), (lap > 3) ? 32'd3 : 32'(lap));
      chk($sformatf("lap%0d.w2_se", lap),   32'(se_w2),   32'h0);
    end
    chk("laps.wrap8", 32'(wrap), 32'd5);
    chk("laps.tc8",   32'(tc),   32'h1);

    // Asynchronous reset mid-cycle while tc_pulse is high.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    rst_n = 1'b1;
    step(0, 0, 0);
    chk_all_zero("post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Downstream consumer of the 3-bit up-counter's data_out bus. Samples the count on a strobe and checks that it advances by exactly one, modulo 2^CNT_W.
- Counts wrap-arounds and flags sequence errors, with a sticky fault after repeated errors.
- Provides a registered one-hot decode of the current count for downstream phase-select logic.

Parameters:
- CNT_W, 3, width of monitored count; legal range 0..2^CNT_W-1.
- WRAP_W, 8, width of the wrap counter; saturates.
- ERR_W, 8, width of the total-error counter; saturates.
- ERR_LIMIT, 3, consecutive sequence errors that force FAULT; legal range 1..15.
- HOLD_OK, 1, 1 = a repeated value is a legal stall; 0 = a repeat is an error.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear: counters, sticky fault, back to ACQUIRE.
- count_vld  in  1  count_in is valid this cycle.
- count_in  in  CNT_W  counter value under check.
- onehot_out  out  2**CNT_W  registered decode of the last accepted sample.
- tc_pulse  out  1  one-cycle pulse on a legal max->0 wrap.
- wrap_count  out  WRAP_W  number of legal wraps; saturates at all-ones.
- seq_err  out  1  one-cycle pulse on an illegal transition.
- err_count  out  ERR_W  total errors; saturates.
- locked  out  1  high in TRACK.
- fault  out  1  high in FAULT; sticky until clr or reset.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=ACQUIRE.
  - onehot_out=0, tc_pulse=0, seq_err=0.
  - wrap_count=0, err_count=0, consec_err=0.
  - prev=0, locked=0, fault=0.
- All outputs are registered. Latency from a sample with count_vld=1 to its outputs is 1 cycle. With count_vld=0, state and outputs hold and pulses are 0.
- exp = prev+1, truncated to CNT_W bits, so max+1 = 0.
- ACQUIRE, on count_vld:
  - prev<=count_in; onehot_out<=1<<count_in; go to TRACK.
  - No check, no tc_pulse.
- TRACK, on count_vld:
  - count_in==exp: legal. prev<=count_in, onehot update, consec_err<=0.
    - If additionally prev==max and count_in==0: tc_pulse=1 and wrap_count++ (saturating).
  - count_in==prev and HOLD_OK=1: legal stall. No change except consec_err<=0.
  - Otherwise: seq_err=1, err_count++ (saturating), consec_err++. Resync: prev<=count_in, onehot update.
    - If consec_err+1 == ERR_LIMIT: go to FAULT.
- FAULT:
  - fault=1, locked=0, onehot_out=0.
  - Samples are ignored and counters are frozen.
  - Exit only via clr or rst_n.
- clr:
  - Same cycle as count_vld: clr wins and the sample is discarded.
  - Next cycle: ACQUIRE with all counters 0 and outputs as at reset.
- A single error never unlocks; locked stays 1 in TRACK through resync.
- Reset mid-operation: immediate return to reset values, with no pulse glitch on tc_pulse or seq_err.
- locked = (state==TRACK), registered.

Decomposition:
- Shared package (cnt_pkg):
  - state enum {ACQUIRE, TRACK, FAULT}, 2 bits.
  - Default CNT_W constant.
  - sat_inc function for saturating increment.
- One sub-module, onehot_dec: parameterised CNT_W-to-2**CNT_W combinational decoder with an enable input. The output register stays in the parent.

Test Plan:
- Reset, then count_vld=1 with count_in 0,1,...,7,0,1 -> locked=1 after the first sample; tc_pulse exactly once (cycle after 7->0); wrap_count=1; seq_err never; onehot_out=8'h02 after last sample.
- Sequence 3,4,6,7 -> seq_err pulse on 6; err_count=1; consec_err cleared by 7; locked stays 1; onehot_out=8'h80.
- HOLD_OK=1, sequence 2,2,3 -> no error; HOLD_OK=0, same sequence -> one seq_err at the second 2.
- ERR_LIMIT=3, sequence 0,5,2,7 -> three seq_err pulses, then fault=1, locked=0, onehot_out=0; later samples leave err_count=3 and wrap_count unchanged.
- From FAULT, assert clr together with count_vld=1, count_in=4 -> sample ignored; next cycle ACQUIRE with all counters 0; next sample 5 -> locked=1, onehot_out=8'h20.
- WRAP_W=2, run 5 full wraps -> wrap_count saturates at 3; tc_pulse still fires on every wrap. Assert rst_n=0 mid-sequence -> all outputs 0 asynchronously.
